// File: rtl/toggle_div_pkg.sv
// Shared types and constants for the toggle divider controller:
// FSM state encoding, prescaler/select widths and the tick mask helper.
package toggle_div_pkg;

  localparam int PCNT_W = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Low sel+1 bits set: the prescaler pattern that ends one divided period.
  function automatic logic [PCNT_W-1:0] tick_mask(input logic [SEL_W-1:0] sel);
    return PCNT_W'((2 << sel) - 1);
  endfunction

endpackage

// File: rtl/toggle_stage.sv
// One prescaler bit: T flip-flop that toggles when en_i is high,
// cleared asynchronously by the active-low reset.
module toggle_stage (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= 1'b0;
    end else if (en_i) begin
      q_o <= ~q_o;
    end
  end

endmodule

// File: rtl/toggle_div_ctrl.sv
// Clock-enable style divider (/2../16) with continuous and one-shot modes.
// One-shot support (mode, count_n, DONE) is built only with TOGGLE_DIV_ONESHOT_EN.
module toggle_div_ctrl
  import toggle_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [SEL_W-1:0] div_sel_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] count_n_i,
  output logic             div_out_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [PCNT_W-1:0]   pcnt_q;
  logic [PCNT_W-1:0]   stage_en;
  logic [PCNT_W-1:0]   carry;
  logic [PCNT_W-1:0]   mask;
  logic                run;
  logic                tick_hit;
  logic                pcnt_clr;

`ifdef TOGGLE_DIV_ONESHOT_EN
  logic                mode_q;
  logic [CNT_W-1:0]    rem_q;
`else
  logic                unused_oneshot;
  assign unused_oneshot = ^{mode_i, count_n_i};
`endif

  assign run      = (state_q == RUN);
  assign mask     = tick_mask(sel_q);
  assign tick_hit = run && ((pcnt_q & mask) == mask);
  assign pcnt_clr = !run || stop_i;

  // Clearing reuses the toggle enables: flipping every set bit zeroes the counter.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < PCNT_W; i++) begin : g_stage
    if (i + 1 < PCNT_W) begin : g_carry
      assign carry[i+1] = carry[i] & pcnt_q[i];
    end
    assign stage_en[i] = pcnt_clr ? pcnt_q[i] : carry[i];
    toggle_stage u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (stage_en[i]),
      .q_o    (pcnt_q[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
`ifdef TOGGLE_DIV_ONESHOT_EN
      mode_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= RUN;
            sel_q   <= div_sel_i;
`ifdef TOGGLE_DIV_ONESHOT_EN
            mode_q  <= mode_i;
            rem_q   <= count_n_i;
`endif
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
`ifdef TOGGLE_DIV_ONESHOT_EN
            rem_q   <= '0;
`endif
          end
`ifdef TOGGLE_DIV_ONESHOT_EN
          // A zero count finishes at once; otherwise the tick taking rem to zero ends the run.
          else if (mode_q) begin
            if (rem_q == '0) begin
              state_q <= DONE;
            end else if (tick_hit) begin
              rem_q <= rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_q <= DONE;
              end
            end
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = run;
  assign div_out_o = run && pcnt_q[sel_q];
  assign tick_o    = tick_hit && !stop_i;
`ifdef TOGGLE_DIV_ONESHOT_EN
  assign done_o    = (state_q == DONE);
`else
  assign done_o    = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_div_ctrl.sv
// Scoreboard bench for toggle_div_ctrl: tick/done events are predicted per run from
// the period arithmetic and matched by a free-running monitor; busy/div_out checked every cycle.
module tb_toggle_div_ctrl;

  localparam int CNT_W = 8;

  typedef struct {
    int cyc;
    bit isDone;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       divSel = '0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] countN = '0;
  logic             divOut;
  logic             tick;
  logic             busy;
  logic             done;

  int   edgeCount = 0;
  int   checks = 0;
  int   fails = 0;
  ev_t  evQ[$];
  bit   mValid = 1'b0;
  int   mE0 = 0;
  int   mLast = 0;
  int   mP = 2;

  toggle_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .stop_i    (stop),
    .div_sel_i (divSel),
    .mode_i    (mode),
    .count_n_i (countN),
    .div_out_o (divOut),
    .tick_o    (tick),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // Monitor: busy/div_out follow the square-wave model; every tick/done pops the scoreboard.
  always @(negedge clk) begin
    int  r;
    bit  inRun;
    ev_t e;
    r     = edgeCount - mE0 + 1;
    inRun = mValid && (r >= 1) && (r <= mLast);
    checkOutput("busy", int'(busy), int'(inRun));
    checkOutput("divOut", int'(divOut), (inRun && (((r - 1) % mP) >= mP / 2)) ? 1 : 0);
    if (tick || done) begin
      if (evQ.size() == 0) begin
        checkOutput("unexpectedEvent", tick ? 1 : 2, 0);
      end else begin
        e = evQ.pop_front();
        checkOutput("eventCycle", edgeCount, e.cyc);
        checkOutput("eventIsDone", int'(done), int'(e.isDone));
        checkOutput("eventIsTick", int'(tick), int'(!e.isDone));
      end
    end
  end

  task automatic idleCycle();
    @(posedge clk);
    #2;
    divSel = 2'($urandom);
    mode   = 1'($urandom);
    countN = CNT_W'($urandom);
  endtask

  // One run: stopAt>0 stops in that run cycle, 0 lets it finish, -1 picks at random.
  task automatic applyStimulus(input int sel, input int md, input int n, input int stopAt);
    int  p;
    int  natEnd;
    int  last;
    int  e0;
    bit  oneshot;
    p = 2 << sel;
`ifdef TOGGLE_DIV_ONESHOT_EN
    oneshot = (md == 1);
`else
    oneshot = 1'b0;
`endif
    natEnd = oneshot ? ((n == 0) ? 1 : n * p) : 0;
    if (stopAt < 0) begin
      if (oneshot) stopAt = ($urandom_range(2, 0) == 0) ? int'($urandom_range(natEnd, 1)) : 0;
      else         stopAt = int'($urandom_range(50, 1));
    end
    if (!oneshot && stopAt == 0) stopAt = 3 * p + 1 + int'($urandom_range(p - 1, 0));
    if (oneshot && stopAt > natEnd) stopAt = 0;
    last = (stopAt != 0) ? stopAt : natEnd;

    @(posedge clk);
    #2;
    e0 = edgeCount + 1;
    for (int k = 1; k * p <= last; k++) begin
      if (!(stopAt != 0 && k * p == stopAt)) evQ.push_back('{cyc: e0 + k * p - 1, isDone: 1'b0});
    end
    if (oneshot && stopAt == 0) evQ.push_back('{cyc: e0 + natEnd, isDone: 1'b1});
    mE0 = e0; mLast = last; mP = p; mValid = 1'b1;
    start = 1'b1; divSel = 2'(sel); mode = 1'(md); countN = CNT_W'(n);
    @(posedge clk);
    #2;
    start = 1'b0;
    if (stopAt != 0) begin
      repeat (stopAt - 1) idleCycle();
      stop = 1'b1;
      @(posedge clk);
      #2;
      stop = 1'b0;
    end else begin
      repeat (natEnd) idleCycle();
    end
    repeat (3) idleCycle();
    checkOutput("pendingEvents", evQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDivOut", int'(divOut), 0);
    checkOutput("resetTick", int'(tick), 0);
    checkOutput("resetDone", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) idleCycle();

    // Directed scenarios first, then randomized runs.
    applyStimulus(1, 0, 0, 13);
    applyStimulus(3, 1, 3, 0);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(0, 1, 5, 10);

    @(posedge clk);
    #2;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0; stop = 1'b0;
    repeat (3) idleCycle();
    checkOutput("busyAfterStartStop", int'(busy), 0);

    applyStimulus(1, 1, 2, 0);

    @(posedge clk);
    #2;
    mE0 = edgeCount + 1; mLast = 100000; mP = 8; mValid = 1'b1;
    start = 1'b1; divSel = 2'd2; mode = 1'b0;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (6) idleCycle();
    #1;
    mValid = 1'b0;
    evQ.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("midRunResetBusy", int'(busy), 0);
    checkOutput("midRunResetDivOut", int'(divOut), 0);
    checkOutput("midRunResetTick", int'(tick), 0);
    checkOutput("midRunResetDone", int'(done), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) idleCycle();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(3, 0)), int'($urandom_range(1, 0)), int'($urandom_range(6, 0)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/toggle_div_ctrl.md
TOGGLE_DIV_CTRL -- requirements
Module: toggle_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the one-shot tick count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to begin division; sampled in IDLE only.
REQ-005 SHALL have port stop  input  1  abort request; sampled in RUN and in IDLE.
REQ-006 SHALL have port div_sel  input  2  divide select: 0:/2, 1:/4, 2:/8, 3:/16.
REQ-007 SHALL have port mode  input  1  0: continuous, 1: one-shot.
REQ-008 SHALL have port count_n  input  CNT_W  number of ticks in one-shot mode.
REQ-009 SHALL have port div_out  output  1  divided square wave.
REQ-010 SHALL have port tick  output  1  one-cycle pulse at the end of each divided period.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL move IDLE->RUN on start=1 and stop=0, latching div_sel, mode and count_n into internal registers on that edge.
REQ-015 SHALL stay in IDLE when start and stop are both 1 in the same cycle (stop wins).
REQ-016 SHALL clear the 4-bit prescaler pcnt to 0 on the IDLE->RUN edge and increment it by 1 every cycle in RUN.
REQ-017 SHALL drive div_out = pcnt[sel_q] in RUN and 0 otherwise, giving a period of 2^(sel_q+1) cycles at 50% duty.
REQ-018 SHALL assert tick when in RUN and pcnt[sel_q:0] is all ones; the first tick occurs 2^(sel_q+1) cycles after the start edge.
REQ-019 SHALL wrap pcnt modulo 16 with no stall, so ticks repeat every 2^(sel_q+1) cycles.
REQ-020 SHALL ignore div_sel, mode, count_n and start while in RUN or DONE.
REQ-021 SHALL, in one-shot mode, decrement a remaining-count register rem (loaded from count_n) on each tick.
REQ-022 SHALL, in one-shot mode, go RUN->DONE on the tick where rem==1; that tick is still emitted.
REQ-023 SHALL go RUN->DONE on the first RUN cycle when one-shot mode has count_n==0, with no tick emitted.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL move RUN->IDLE on stop=1 on the next edge: no done, pcnt and rem cleared, and no tick in the stop cycle.
REQ-026 SHALL give stop priority over a coincident final tick: tick is suppressed and done is not asserted.
REQ-027 SHALL never leave continuous mode except via stop or reset.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, pcnt=0, rem=0, all latched config=0, and div_out=tick=busy=done=0, independent of clk.
REQ-029 SHALL, on reset assertion mid-RUN, abort immediately with no done pulse.
REQ-030 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL support the macro TOGGLE_DIV_ONESHOT_EN.
REQ-032 SHALL, with TOGGLE_DIV_ONESHOT_EN defined, implement mode, count_n, rem and the DONE state as specified above.
REQ-033 SHALL, without TOGGLE_DIV_ONESHOT_EN, keep the mode and count_n ports but ignore them, omit rem, behave as continuous always, and tie done to 0.

Structure
REQ-034 SHALL take the state enum (IDLE, RUN, DONE) and the constants PCNT_W=4 and SEL_W=2 from shared package toggle_div_pkg.
REQ-035 SHALL build the prescaler from a sub-module toggle_stage: a synchronous-enable T flip-flop with async active-low clear, instantiated 4 times, with stage i enabled by the AND of stages 0..i-1.
REQ-036 SHALL use no derived or gated clocks; all flops SHALL be on clk.

Verification
REQ-037 SHALL cover: reset, then start with div_sel=1, mode=0 -> ticks at cycles 4, 8, 12 after start; div_out = 0,0,1,1 repeating; busy=1.
REQ-038 SHALL cover: div_sel=3, mode=1, count_n=3 -> ticks at cycles 16, 32, 48; done one cycle after the third tick; busy=0 after that.
REQ-039 SHALL cover: mode=1, count_n=0 -> done 2 cycles after the start edge, no tick.
REQ-040 SHALL cover: div_sel=0, mode=1, count_n=5 with stop asserted in the cycle of the 5th tick -> tick suppressed, no done, IDLE on the next cycle.
REQ-041 SHALL cover: start and stop together in IDLE -> stays IDLE; rst_n pulled low mid-RUN -> all outputs 0 asynchronously.
REQ-042 SHALL cover: build without TOGGLE_DIV_ONESHOT_EN, mode=1, count_n=2 -> ticks continue past 2, done stays 0.
